// File: rtl/histeq_map_pp.sv
// Histogram-equalisation pixel mapper with a ping-pong CDF LUT swapped at frame start.
// Define HISTEQ_BYPASS_EN to add cfg_bypass, which passes pixels through unmapped.
module histeq_map_pp #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 21,
  parameter int unsigned MULT_W = 24,
  parameter int unsigned SHIFT  = 32,
  parameter int unsigned MULT   = 2281701
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef HISTEQ_BYPASS_EN
  input  logic              cfg_bypass,
`endif
  input  logic              pre_img_vsync,
  input  logic              pre_img_hsync,
  input  logic              pre_img_valid,
  input  logic [DATA_W-1:0] pre_img_gray,
  input  logic              lut_wr_vld,
  input  logic [DATA_W-1:0] lut_wr_addr,
  input  logic [CNT_W-1:0]  lut_wr_data,
  input  logic              lut_wr_last,
  output logic              lut_ready,
  output logic              lut_load_done,
  output logic              lut_wr_drop,
  output logic              active_bank,
  output logic              post_img_vsync,
  output logic              post_img_hsync,
  output logic              post_img_valid,
  output logic [DATA_W-1:0] post_img_gray
);

  localparam int unsigned LEVELS = 1 << DATA_W;
  localparam int unsigned PROD_W = CNT_W + MULT_W;
  localparam logic [MULT_W-1:0] MULT_C  = MULT_W'(MULT);
  localparam logic [PROD_W-1:0] ROUND_C = PROD_W'(1) << (SHIFT - 1);
  localparam logic [PROD_W-1:0] MAX_LVL = PROD_W'(LEVELS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PEND} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  bank0 [LEVELS];
  logic [CNT_W-1:0]  bank1 [LEVELS];
  logic              vsync_d;
  logic              frame_start_c, wr_en_c, swap_c, drop_c, byp_in_c;
  logic [CNT_W-1:0]  rd_cnt_c;
  logic [PROD_W-1:0] q_c;
  logic [DATA_W-1:0] sat_c;
  logic [2:0]        vs_sr, hs_sr;
  logic              v1, v2, byp1, byp2;
  logic [CNT_W-1:0]  cnt1;
  logic [DATA_W-1:0] gray1, gray2;
  logic [PROD_W-1:0] prod2;

`ifdef HISTEQ_BYPASS_EN
  assign byp_in_c = cfg_bypass;
`else
  assign byp_in_c = 1'b0;
`endif

  assign frame_start_c = pre_img_vsync & ~vsync_d;

  // Load FSM: writes go to the shadow bank until the last one, then wait for a frame start.
  always_comb begin
    state_next = state;
    wr_en_c    = 1'b0;
    swap_c     = 1'b0;
    drop_c     = 1'b0;
    case (state)
      IDLE, LOAD: begin
        if (lut_wr_vld) begin
          wr_en_c    = 1'b1;
          state_next = lut_wr_last ? PEND : LOAD;
        end
      end
      PEND: begin
        drop_c = lut_wr_vld;
        if (frame_start_c) begin
          swap_c     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      vsync_d       <= 1'b0;
      active_bank   <= 1'b0;
      lut_ready     <= 1'b0;
      lut_load_done <= 1'b0;
      lut_wr_drop   <= 1'b0;
    end else begin
      state         <= state_next;
      vsync_d       <= pre_img_vsync;
      active_bank   <= active_bank ^ swap_c;
      lut_ready     <= (state_next != PEND);
      lut_load_done <= swap_c;
      lut_wr_drop   <= drop_c;
    end
  end

  // The shadow bank is always the one not selected by active_bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LEVELS; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else if (wr_en_c) begin
      if (active_bank) bank0[lut_wr_addr] <= lut_wr_data;
      else             bank1[lut_wr_addr] <= lut_wr_data;
    end
  end

  assign rd_cnt_c = active_bank ? bank1[pre_img_gray] : bank0[pre_img_gray];
  assign q_c      = prod2 >> SHIFT;
  assign sat_c    = (q_c > MAX_LVL) ? {DATA_W{1'b1}} : DATA_W'(q_c);

  // Three-stage map pipeline: LUT read, scale with rounding, shift and saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_sr          <= '0;
      hs_sr          <= '0;
      v1             <= 1'b0;
      v2             <= 1'b0;
      post_img_valid <= 1'b0;
      cnt1           <= '0;
      gray1          <= '0;
      byp1           <= 1'b0;
      prod2          <= '0;
      gray2          <= '0;
      byp2           <= 1'b0;
      post_img_gray  <= '0;
    end else begin
      vs_sr          <= {vs_sr[1:0], pre_img_vsync};
      hs_sr          <= {hs_sr[1:0], pre_img_hsync};
      v1             <= pre_img_valid;
      v2             <= v1;
      post_img_valid <= v2;
      if (pre_img_valid) begin
        cnt1  <= rd_cnt_c;
        gray1 <= pre_img_gray;
        byp1  <= byp_in_c;
      end
      if (v1) begin
        prod2 <= PROD_W'(cnt1) * PROD_W'(MULT_C) + ROUND_C;
        gray2 <= gray1;
        byp2  <= byp1;
      end
      if (v2) post_img_gray <= byp2 ? gray2 : sat_c;
    end
  end

  assign post_img_vsync = vs_sr[2];
  assign post_img_hsync = hs_sr[2];

endmodule
